// File: rtl/clfsr_keystream_ctrl_pkg.sv
// Shared types and constants for the chaotic-LFSR keystream generator.
// Holds the controller state encoding, LFSR taps and core reset values.
package clfsr_keystream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WARMUP = 2'd2,
    ST_RUN    = 2'd3
  } ctrl_state_e;

  // Taps at bits 15, 13, 12 and 10.
  localparam logic [15:0]        LFSR_TAPS         = 16'hB400;
  localparam logic [15:0]        DEFAULT_SEED_LFSR = 16'h0001;
  localparam logic signed [15:0] DEFAULT_SEED_X    = 16'sh7EF0;
  localparam logic signed [15:0] X_ONE             = 16'sh7FFF;

  function automatic logic lfsr_feedback(input logic [15:0] v);
    return ^(v & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/clfsr_keystream_ctrl_core.sv
// Keystream datapath: 16-bit Fibonacci LFSR mixed with a pipelined logistic-style
// chaotic map; one output bit per enabled cycle.
module clfsr_core
  import clfsr_keystream_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] seed_lfsr,
  input  logic [15:0] seed_x,
  output logic        bit_out
);

  logic [15:0]        lfsr_q;
  logic signed [15:0] x_q;
  logic signed [31:0] sq_q;
  logic signed [31:0] mult_q;
  logic signed [15:0] x_next;
  logic               unused_mult_bits;

  // x_q, sq_q and mult_q form a three-register feedback loop, so the map runs as
  // three interleaved chains: each x_next is f() of the value three steps earlier.
  assign x_next           = X_ONE - $signed(mult_q[30:15]);
  assign bit_out          = lfsr_q[15] ^ x_next[15];
  assign unused_mult_bits = ^{mult_q[31], mult_q[14:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= DEFAULT_SEED_LFSR;
      x_q    <= DEFAULT_SEED_X;
      sq_q   <= '0;
      mult_q <= '0;
    end else if (load) begin
      lfsr_q <= seed_lfsr;
      x_q    <= $signed(seed_x);
      sq_q   <= '0;
      mult_q <= '0;
    end else if (en) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_feedback(lfsr_q)};
      sq_q   <= 32'(x_q) * 32'(x_q);
      mult_q <= sq_q <<< 2;
      x_q    <= x_next;
    end
  end

endmodule

// File: rtl/clfsr_keystream_ctrl.sv
// Keystream controller: seeds the core, discards a warm-up run, then packs core
// bits MSB-first into bytes offered on a valid/ready output.
module clfsr_keystream_ctrl
  import clfsr_keystream_ctrl_pkg::*;
#(
  parameter int WARMUP_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_valid,
  output logic        seed_ready,
  input  logic [15:0] seed_lfsr,
  input  logic [15:0] seed_x,
  input  logic        stop,
  output logic [7:0]  key_byte,
  output logic        key_valid,
  input  logic        key_ready,
  output logic        busy,
  output logic [15:0] key_count,
  output logic [1:0]  dbg_state_o
);

  // Valid/ready: a transfer happens on a rising edge where both are high; valid
  // never waits on ready, and data holds steady while valid && !ready.

  localparam logic [15:0] WARM_LAST = 16'(WARMUP_CYCLES - 1);

  ctrl_state_e state_q;
  logic [15:0] warm_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  shreg_q;
  logic [7:0]  key_byte_q;
  logic        key_valid_q;
  logic [15:0] key_count_q;
  logic [15:0] seed_lfsr_q;
  logic [15:0] seed_x_q;

  logic core_bit;
  logic accept;
  logic stall;
  logic core_en;
  logic core_load;

  assign accept    = key_valid_q && key_ready;
  assign stall     = (bit_cnt_q == 3'd7) && key_valid_q && !key_ready;
  assign core_en   = (state_q == ST_WARMUP) || ((state_q == ST_RUN) && !stall);
  assign core_load = (state_q == ST_LOAD);

  assign seed_ready  = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign key_byte    = key_byte_q;
  assign key_valid   = key_valid_q;
  assign key_count   = key_count_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      warm_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      key_byte_q  <= '0;
      key_valid_q <= 1'b0;
      key_count_q <= '0;
      seed_lfsr_q <= DEFAULT_SEED_LFSR;
      seed_x_q    <= DEFAULT_SEED_X;
    end else begin
      // Counted even when stop arrives in the same cycle.
      if (accept) key_count_q <= key_count_q + 16'd1;

      case (state_q)
        ST_IDLE: begin
          if (seed_valid) begin
            seed_lfsr_q <= (seed_lfsr == 16'h0000) ? 16'h0001 : seed_lfsr;
            seed_x_q    <= seed_x;
            key_count_q <= '0;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else begin
            warm_cnt_q <= '0;
            state_q    <= ST_WARMUP;
          end
        end
        ST_WARMUP: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (warm_cnt_q == WARM_LAST) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            state_q   <= ST_RUN;
          end else begin
            warm_cnt_q <= warm_cnt_q + 16'd1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q     <= ST_IDLE;
            key_valid_q <= 1'b0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
          end else begin
            if (accept) key_valid_q <= 1'b0;
            // A byte finishing on the acceptance edge reloads with no bubble.
            if (core_en) begin
              if (bit_cnt_q == 3'd7) begin
                key_byte_q  <= {shreg_q, core_bit};
                key_valid_q <= 1'b1;
                bit_cnt_q   <= '0;
              end else begin
                shreg_q   <= {shreg_q[5:0], core_bit};
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  clfsr_core u_core (
    .clk       (clk),
    .rst       (rst),
    .en        (core_en),
    .load      (core_load),
    .seed_lfsr (seed_lfsr_q),
    .seed_x    (seed_x_q),
    .bit_out   (core_bit)
  );

endmodule

// File: tb/tb_clfsr_keystream_ctrl.sv
// Randomized scoreboard bench for clfsr_keystream_ctrl against a sequence-level
// model of the keystream recurrence.
module tb_clfsr_keystream_ctrl;

  localparam int W = 64;

  logic        clk;
  logic        rst;
  logic        seed_valid;
  logic        seed_ready;
  logic [15:0] seed_lfsr;
  logic [15:0] seed_x;
  logic        stop;
  logic [7:0]  key_byte;
  logic        key_valid;
  logic        key_ready;
  logic        busy;
  logic [15:0] key_count;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int last_acc_cyc = 0;
  logic [7:0] exp_q[$];

  clfsr_keystream_ctrl #(.WARMUP_CYCLES(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .seed_valid  (seed_valid),
    .seed_ready  (seed_ready),
    .seed_lfsr   (seed_lfsr),
    .seed_x      (seed_x),
    .stop        (stop),
    .key_byte    (key_byte),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .busy        (busy),
    .key_count   (key_count),
    .dbg_state_o (dbg_state_o)
  );

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model
  function automatic logic [15:0] chaos_f(input logic [15:0] x);
    longint v;
    longint sq;
    logic [31:0] m;
    v  = longint'($signed(x));
    sq = v * v;
    m  = 32'(sq * 4);
    return 16'h7FFF - m[30:15];
  endfunction

  // Step k: bit = lfsr_k[15] ^ xn_k[15]; the map has three-step feedback latency,
  // with two 0x7FFF priming values ahead of f(seed). Steps below W are discarded.
  task automatic model_push(input logic [15:0] sl, input logic [15:0] sx, input int nbytes);
    logic [15:0] l;
    logic [15:0] xs[$];
    logic [15:0] xk;
    logic [7:0]  b;
    int          nb;
    l  = (sl == 16'h0000) ? 16'h0001 : sl;
    b  = '0;
    nb = 0;
    for (int k = 0; k < W + 8 * nbytes; k++) begin
      if (k < 2)       xk = 16'h7FFF;
      else if (k == 2) xk = chaos_f(sx);
      else             xk = chaos_f(xs[k-3]);
      xs.push_back(xk);
      if (k >= W) begin
        b = {b[6:0], l[15] ^ xk[15]};
        nb++;
        if (nb == 8) begin
          exp_q.push_back(b);
          nb = 0;
        end
      end
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (!rst && key_valid && key_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got 0x%02h expected none", key_byte);
      end else begin
        exp_b = exp_q.pop_front();
        if (key_byte !== exp_b) begin
          errors++;
          $display("FAIL key_byte: got 0x%02h expected 0x%02h", key_byte, exp_b);
        end
      end
      acc_cnt++;
      last_acc_cyc = cyc;
    end
  end

  // Driver tasks
  task automatic do_seed(input logic [15:0] sl, input logic [15:0] sx, output int t0);
    @(posedge clk); #1;
    seed_valid = 1'b1;
    seed_lfsr  = sl;
    seed_x     = sx;
    t0         = cyc;
    check("seed_ready_idle", 32'(seed_ready), 32'd1);
    @(posedge clk); #1;
    seed_valid = 1'b0;
  endtask

  task automatic wait_valid(output int tv);
    int n;
    tv = -1;
    n  = 0;
    while (tv < 0 && n < 400) begin
      @(negedge clk);
      if (key_valid) tv = cyc;
      n++;
    end
    if (tv < 0) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_acc(input int target);
    int n;
    n = 0;
    while (n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (acc_cnt >= target) break;
    end
    if (acc_cnt < target) check("accept_timeout", 32'(acc_cnt), 32'(target));
  endtask

  task automatic do_stop();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_seed_ready", 32'(seed_ready), 32'd1);
    check("stop_key_valid", 32'(key_valid), 32'd0);
  endtask

  initial begin
    int t0, tv, base, n, bad;
    logic [15:0] sl, sx;
    logic [7:0]  held;

    rst = 1'b1; seed_valid = 1'b0; seed_lfsr = '0; seed_x = '0;
    stop = 1'b0; key_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_seed_ready", 32'(seed_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_count", 32'(key_count), 32'd0);
    check("rst_key_byte", 32'(key_byte), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'd0);

    // Default seeds, full-rate consumer
    key_ready = 1'b1;
    base = acc_cnt;
    model_push(16'h0001, 16'h7EF0, 16);
    do_seed(16'h0001, 16'h7EF0, t0);
    check("busy_after_seed", 32'(busy), 32'd1);
    wait_valid(tv);
    check("first_valid_latency", 32'(tv - t0), 32'(W + 10));
    wait_acc(base + 16);
    key_ready = 1'b0;
    check("byte_cadence", 32'(last_acc_cyc - tv), 32'd120);
    check("key_count_16", 32'(key_count), 32'd16);
    do_stop();

    // Zero LFSR seed behaves as 0x0001
    sx = 16'($urandom());
    key_ready = 1'b1;
    base = acc_cnt;
    model_push(16'h0001, sx, 8);
    do_seed(16'h0000, sx, t0);
    wait_acc(base + 8);
    key_ready = 1'b0;
    check("key_count_zero_seed", 32'(key_count), 32'd8);
    do_stop();

    // Back-pressure hold, random ready, ignored reseed during RUN
    sl = 16'($urandom_range(1, 65535));
    sx = 16'($urandom());
    base = acc_cnt;
    model_push(sl, sx, 12);
    do_seed(sl, sx, t0);
    wait_valid(tv);
    held = key_byte;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!key_valid || key_byte !== held) bad++;
      if (i == 10) begin
        check("seed_ready_in_run", 32'(seed_ready), 32'd0);
      end
    end
    check("hold_stable_cycles_bad", 32'(bad), 32'd0);
    n = 0;
    while (n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (acc_cnt >= base + 12) break;
      key_ready  = 1'($urandom_range(0, 1));
      seed_valid = (n == 25 || n == 60);
      seed_lfsr  = 16'($urandom());
      seed_x     = 16'($urandom());
    end
    key_ready = 1'b0;
    seed_valid = 1'b0;
    check("random_accepts", 32'(acc_cnt - base), 32'd12);
    check("key_count_random", 32'(key_count), 32'd12);
    do_stop();

    // Stop on the cycle of the 8th bit of byte 3
    sl = 16'($urandom_range(1, 65535));
    sx = 16'($urandom());
    key_ready = 1'b1;
    base = acc_cnt;
    model_push(sl, sx, 2);
    do_seed(sl, sx, t0);
    while (cyc < t0 + W + 25) begin
      @(posedge clk); #1;
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("stop8_busy", 32'(busy), 32'd0);
    check("stop8_key_valid", 32'(key_valid), 32'd0);
    check("stop8_seed_ready", 32'(seed_ready), 32'd1);
    check("stop8_key_count", 32'(key_count), 32'd2);
    repeat (20) @(posedge clk);
    #1;
    check("stop8_accepts", 32'(acc_cnt - base), 32'd2);
    key_ready = 1'b0;

    // Stop in the same cycle the first byte is accepted
    sl = 16'($urandom_range(1, 65535));
    sx = 16'($urandom());
    key_ready = 1'b1;
    base = acc_cnt;
    model_push(sl, sx, 1);
    do_seed(sl, sx, t0);
    while (cyc < t0 + W + 10) begin
      @(posedge clk); #1;
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    key_ready = 1'b0;
    check("stop_acc_key_count", 32'(key_count), 32'd1);
    check("stop_acc_key_valid", 32'(key_valid), 32'd0);
    check("stop_acc_busy", 32'(busy), 32'd0);

    // Reset mid-stream overrides seed_valid and stop
    sl = 16'($urandom_range(1, 65535));
    sx = 16'($urandom());
    key_ready = 1'b1;
    base = acc_cnt;
    model_push(sl, sx, 3);
    do_seed(sl, sx, t0);
    wait_acc(base + 3);
    key_ready = 1'b0;
    wait_valid(tv);
    @(posedge clk); #1;
    rst = 1'b1; seed_valid = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; seed_valid = 1'b0; stop = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_key_valid", 32'(key_valid), 32'd0);
    check("mid_rst_key_count", 32'(key_count), 32'd0);
    check("mid_rst_key_byte", 32'(key_byte), 32'd0);
    check("mid_rst_seed_ready", 32'(seed_ready), 32'd1);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
